// File: rtl/serial_link_pkg.sv
// Shared definitions for the enable-gated serial link (state encoding, counter sizing).
package serial_link_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   // Bit-counter width for a word of w bits; never narrower than one bit.
   function automatic int cnt_width(input int w);
      int r;
      r = $clog2(w);
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready load, one bit per enabled cycle,
// registered one-cycle done pulse on the first IDLE cycle after the last bit.
//
//   state    | meaning
//   ST_IDLE  | ready for a word, serial outputs parked low
//   ST_SHIFT | word captured, one bit leaves per cycle with i_EN=1
module piso_serializer
   import serial_link_pkg::*;
#(
   parameter int WIDTH     = 10,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             i_CLK,
   input  logic             i_RST,
   input  logic             i_EN,
   input  logic [WIDTH-1:0] i_DATA,
   input  logic             i_VALID,
   output logic             o_READY,
   output logic             o_SO,
   output logic             o_SO_EN,
   output logic             o_BUSY,
   output logic             o_DONE
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic             state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q <= ST_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (state_q == ST_IDLE) begin
         if (i_VALID) begin
            sreg_d  = i_DATA;
            cnt_d   = '0;
            state_d = ST_SHIFT;
         end
      end else begin
         if (i_EN) begin
            // Shift toward whichever end feeds o_SO; vacated bits fill with zero.
            if (LSB_FIRST) sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            else           sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      o_READY = 1'b0;
      o_BUSY  = 1'b0;
      o_SO    = 1'b0;
      o_SO_EN = 1'b0;
      o_DONE  = done_q;
      if (state_q == ST_IDLE) begin
         o_READY = 1'b1;
      end else begin
         o_BUSY  = 1'b1;
         o_SO    = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
         o_SO_EN = i_EN;
      end
   end

endmodule
